fpadd_sequencer: RTL and testbench
==================================

FPADD_SEQUENCER -- requirements
Module: fpadd_sequencer

Interface
REQ-001 Parameter NUM, default 10: number of operand pairs in the operand ROM.
REQ-002 Parameter DWELL, default 50_000_000: cycles each result is held on the display outputs.
REQ-003 Parameter TIMEOUT, default 64: maximum cycles to wait for an adder result.
REQ-004 Derived constant AW = clog2(NUM), minimum 1: index width.
REQ-005 clk  in  1  sole clock; all state updates on the rising edge.
REQ-006 rst  in  1  asynchronous, active-low reset.
REQ-007 start  in  1  one-cycle pulse that begins a run at index 0.
REQ-008 rom_addr  out  AW  operand ROM address; the ROM has 1-cycle synchronous read.
REQ-009 rom_a, rom_b  in  32 each  IEEE-754 single-precision operands at rom_addr, valid 1 cycle after the address.
REQ-010 add_valid  out  1  one-cycle issue strobe to the FP adder.
REQ-011 add_a, add_b  out  32 each  operands to the adder, stable from issue until the result is accepted.
REQ-012 add_res_valid  in  1  adder result strobe.
REQ-013 add_res  in  32  adder result, sampled when add_res_valid=1.
REQ-014 disp_data  out  32  currently displayed result.
REQ-015 disp_idx  out  AW  index of disp_data.
REQ-016 busy  out  1  high in every state except IDLE and DONE.
REQ-017 done  out  1  one-cycle pulse when a non-looping run completes.
REQ-018 err  out  1  sticky flag: at least one adder timeout since the last start.

Function
REQ-019 FSM states: IDLE, FETCH, LOAD, ISSUE, WAIT, SHOW, DONE.
REQ-020 IDLE or DONE with start=1 -> FETCH; idx := 0; err := 0.
REQ-021 FETCH drives rom_addr=idx for one cycle -> LOAD.
REQ-022 LOAD latches rom_a/rom_b into add_a/add_b -> ISSUE.
REQ-023 ISSUE asserts add_valid for exactly one cycle -> WAIT; the timeout counter clears.
REQ-024 WAIT with add_res_valid=1: disp_data := add_res, disp_idx := idx, dwell counter clears -> SHOW.
REQ-025 WAIT after TIMEOUT cycles without add_res_valid: disp_data := 32'h7FC00000 (quiet NaN), err := 1 -> SHOW.
REQ-026 If add_res_valid and timeout expiry coincide, the result wins and err is unchanged.
REQ-027 SHOW holds for exactly DWELL cycles, then advances: idx<NUM-1 -> idx+1, FETCH; idx=NUM-1 -> per REQ-034/035.
REQ-028 add_res_valid outside WAIT is ignored.
REQ-029 start while busy=1 is ignored.
REQ-030 Issue-to-issue spacing = 3 + result latency + DWELL cycles, with no idle gaps.

Reset
REQ-031 Reset asserted at any time, including mid-WAIT or mid-SHOW, forces IDLE and aborts the run.
REQ-032 Reset values: idx=0, rom_addr=0, add_valid=0, add_a=add_b=0, disp_data=0, disp_idx=0, busy=0, done=0, err=0, counters=0.
REQ-033 An adder result arriving after reset release is ignored (REQ-028).

Configuration
REQ-034 With FPSEQ_LOOP_EN defined: after SHOW of idx=NUM-1, idx wraps to 0 and FETCH follows; DONE is never entered and done stays 0.
REQ-035 Without FPSEQ_LOOP_EN: after SHOW of idx=NUM-1, the FSM goes to DONE, pulses done for one cycle, and holds disp_data/disp_idx.

Structure
REQ-036 Package fpseq_pkg holds the state enum, FP_QNAN = 32'h7FC00000, and the operand/result width constant (32).
REQ-037 Sub-module fpseq_timer: a loadable down-counter with a clear input and a terminal-count output, instantiated once for DWELL and once for TIMEOUT.

Verification
Bench settings: NUM=4, DWELL=5, TIMEOUT=8 unless stated. The adder model has 3-cycle latency.

REQ-038 Operands 1.0+2.0 (3F800000, 40000000) at idx 0, then start -> add_valid 3 cycles later with those operands; disp_data=40400000 4 cycles after issue, held for 5 cycles.
REQ-039 Full run without loop -> disp_idx steps 0,1,2,3; done pulses once after idx 3's dwell; busy=0 afterwards.
REQ-040 With FPSEQ_LOOP_EN -> after idx 3, rom_addr returns to 0; done never asserts.
REQ-041 Adder model silent at idx 2 -> after 8 WAIT cycles, disp_data=7FC00000, err=1; err stays 1 through idx 3 and clears on the next start.
REQ-042 rst low during SHOW of idx 1 -> all outputs at reset values within the same cycle; a later add_res_valid is ignored; a new start begins at idx 0.
REQ-043 start pulsed during WAIT, and add_res_valid on the same cycle as timeout expiry -> start is ignored; the result is displayed and err=0.

Source files
------------

// File: rtl/fpseq_pkg.sv
// Shared types and constants for the fpadd_sequencer slice.
package fpseq_pkg;

  localparam int FP_W = 32;
  localparam logic [FP_W-1:0] FP_QNAN = 32'h7FC0_0000;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_LOAD,
    S_ISSUE,
    S_WAIT,
    S_SHOW,
    S_DONE
  } state_t;

endpackage

// File: rtl/fpseq_timer.sv
// Loadable down-counter that stops at zero. Terminal count is high whenever
// the count is zero.
module fpseq_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_clr,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  input  logic         i_en,
  output logic         o_tc
);

  logic [W-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                      r_cnt <= '0;
    else if (i_clr)                r_cnt <= '0;
    else if (i_load)               r_cnt <= i_load_val;
    else if (i_en && r_cnt != '0)  r_cnt <= r_cnt - W'(1);
  end

  assign o_tc = (r_cnt == '0);

endmodule

// File: rtl/fpadd_sequencer.sv
// Steps through an operand ROM, issues each pair to an external FP adder and
// holds every result on the display outputs. Define FPSEQ_LOOP_EN to loop forever.
module fpadd_sequencer
  import fpseq_pkg::*;
#(
  parameter  int NUM     = 10,
  parameter  int DWELL   = 50_000_000,
  parameter  int TIMEOUT = 64,
  localparam int AW      = (NUM > 1) ? $clog2(NUM) : 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  output logic [AW-1:0]   rom_addr,
  input  logic [FP_W-1:0] rom_a,
  input  logic [FP_W-1:0] rom_b,
  output logic            add_valid,
  output logic [FP_W-1:0] add_a,
  output logic [FP_W-1:0] add_b,
  input  logic            add_res_valid,
  input  logic [FP_W-1:0] add_res,
  output logic [FP_W-1:0] disp_data,
  output logic [AW-1:0]   disp_idx,
  output logic            busy,
  output logic            done,
  output logic            err,
  output state_t          dbg_state
);

  // Adder handshake: add_valid is a single-cycle issue strobe with add_a/add_b
  // held until the result is taken; add_res_valid is sampled only in WAIT.
  localparam int DW = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  state_t            r_state, w_state_nx;
  logic [AW-1:0]     r_idx, r_disp_idx;
  logic [FP_W-1:0]   r_add_a, r_add_b, r_disp_data;
  logic              r_err;
  logic              w_last, w_dw_tc, w_to_tc;
  logic              w_run_start, w_latch, w_res_take, w_timeout, w_advance;
  logic              w_to_load, w_to_en, w_dw_load, w_dw_en, w_tmr_clr;

  assign w_last = (r_idx == AW'(NUM - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_state_nx;
  end

  always_comb begin
    w_state_nx = r_state;
    case (r_state)
      S_IDLE, S_DONE: if (start) w_state_nx = S_FETCH;
      S_FETCH:        w_state_nx = S_LOAD;
      S_LOAD:         w_state_nx = S_ISSUE;
      S_ISSUE:        w_state_nx = S_WAIT;
      S_WAIT:         if (add_res_valid || w_to_tc) w_state_nx = S_SHOW;
      S_SHOW: begin
        if (w_dw_tc) begin
`ifdef FPSEQ_LOOP_EN
          w_state_nx = S_FETCH;
`else
          w_state_nx = w_last ? S_DONE : S_FETCH;
`endif
        end
      end
      default:        w_state_nx = S_IDLE;
    endcase
  end

  always_comb begin
    add_valid   = (r_state == S_ISSUE);
    busy        = (r_state != S_IDLE) && (r_state != S_DONE);
    w_tmr_clr   = !busy;
    w_run_start = !busy && start;
    w_latch     = (r_state == S_LOAD);
    w_res_take  = (r_state == S_WAIT) && add_res_valid;
    // A result arriving on the expiry cycle takes priority over the timeout.
    w_timeout   = (r_state == S_WAIT) && !add_res_valid && w_to_tc;
    w_advance   = (r_state == S_SHOW) && w_dw_tc;
    w_to_load   = (r_state == S_ISSUE);
    w_to_en     = (r_state == S_WAIT);
    w_dw_load   = w_res_take || w_timeout;
    w_dw_en     = (r_state == S_SHOW);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_idx       <= '0;
      r_add_a     <= '0;
      r_add_b     <= '0;
      r_disp_data <= '0;
      r_disp_idx  <= '0;
      r_err       <= 1'b0;
    end else begin
      if (w_run_start) begin
        r_idx <= '0;
        r_err <= 1'b0;
      end else if (w_advance && !w_last) begin
        r_idx <= r_idx + AW'(1);
      end
`ifdef FPSEQ_LOOP_EN
      else if (w_advance) begin
        r_idx <= '0;
      end
`endif
      if (w_latch) begin
        r_add_a <= rom_a;
        r_add_b <= rom_b;
      end
      if (w_res_take) begin
        r_disp_data <= add_res;
        r_disp_idx  <= r_idx;
      end else if (w_timeout) begin
        r_disp_data <= FP_QNAN;
        r_disp_idx  <= r_idx;
        r_err       <= 1'b1;
      end
    end
  end

`ifdef FPSEQ_LOOP_EN
  assign done = 1'b0;
`else
  logic r_done;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_done <= 1'b0;
    else      r_done <= w_advance && w_last;
  end
  assign done = r_done;
`endif

  fpseq_timer #(.W(DW)) u_dwell (
    .clk        (clk),
    .rst        (rst),
    .i_clr      (w_tmr_clr),
    .i_load     (w_dw_load),
    .i_load_val (DW'(DWELL - 1)),
    .i_en       (w_dw_en),
    .o_tc       (w_dw_tc)
  );

  fpseq_timer #(.W(TW)) u_timeout (
    .clk        (clk),
    .rst        (rst),
    .i_clr      (w_tmr_clr),
    .i_load     (w_to_load),
    .i_load_val (TW'(TIMEOUT - 1)),
    .i_en       (w_to_en),
    .o_tc       (w_to_tc)
  );

  assign rom_addr  = r_idx;
  assign add_a     = r_add_a;
  assign add_b     = r_add_b;
  assign disp_data = r_disp_data;
  assign disp_idx  = r_disp_idx;
  assign err       = r_err;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_fpadd_sequencer.sv
// Directed bench for fpadd_sequencer: ROM model, 3-cycle adder model and
// hand-computed IEEE-754 sums. Also builds with FPSEQ_LOOP_EN defined.
`timescale 1ns/1ps
module tb_fpadd_sequencer;
  import fpseq_pkg::*;

  localparam int NUM = 4, DWELL = 5, TIMEOUT = 8, AW = 2;

  logic          clk = 1'b0, rst = 1'b0, start = 1'b0;
  logic [AW-1:0] rom_addr, disp_idx;
  logic [31:0]   rom_a = '0, rom_b = '0, add_a, add_b, disp_data;
  logic          add_valid, busy, done, err;
  logic          add_res_valid = 1'b0;
  logic [31:0]   add_res = '0;
  state_t        dbg_state;

  // 1+2=3, 3+0.5=3.5, 5+(-3)=2, 10+0.25=10.25
  logic [31:0] tab_a [4] = '{32'h3F800000, 32'h40400000, 32'h40A00000, 32'h41200000};
  logic [31:0] tab_b [4] = '{32'h40000000, 32'h3F000000, 32'hC0400000, 32'h3E800000};
  logic [31:0] tab_s [4] = '{32'h40400000, 32'h40600000, 32'h40000000, 32'h41240000};

  int          n_vec = 0, n_err = 0;
  int          lat = 3;
  logic        mute_en = 1'b0;
  logic [31:0] mute_a = '0;
  int          inj_req = 0, inj_ack = 0;
  logic [31:0] exp_q [$];

  fpadd_sequencer #(.NUM(NUM), .DWELL(DWELL), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .start(start), .rom_addr(rom_addr),
    .rom_a(rom_a), .rom_b(rom_b), .add_valid(add_valid),
    .add_a(add_a), .add_b(add_b), .add_res_valid(add_res_valid),
    .add_res(add_res), .disp_data(disp_data), .disp_idx(disp_idx),
    .busy(busy), .done(done), .err(err), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  // ---------------- models ----------------
  always @(posedge clk) begin
    rom_a <= tab_a[rom_addr];
    rom_b <= tab_b[rom_addr];
  end

  function automatic logic [31:0] f_sum(input logic [31:0] a, input logic [31:0] b);
    for (int i = 0; i < NUM; i++)
      if (tab_a[i] == a && tab_b[i] == b) return tab_s[i];
    return 32'h0BAD0000;
  endfunction

  logic        m_pend = 1'b0;
  int          m_cnt = 0;
  logic [31:0] m_sum = '0;
  always @(posedge clk) begin
    add_res_valid <= 1'b0;
    if (m_pend) begin
      if (m_cnt <= 1) begin
        add_res_valid <= 1'b1;
        add_res       <= m_sum;
        m_pend        <= 1'b0;
      end
      m_cnt <= m_cnt - 1;
    end
    if (inj_req != inj_ack) begin
      add_res_valid <= 1'b1;
      add_res       <= 32'hDEADBEEF;
      inj_ack       <= inj_req;
    end
    if (add_valid && !(mute_en && add_a == mute_a)) begin
      m_pend <= 1'b1;
      m_cnt  <= lat - 1;
      m_sum  <= f_sum(add_a, add_b);
    end
  end

  // ---------------- checking / drivers ----------------
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_start();
`ifdef FPSEQ_LOOP_EN
    rst = 1'b0; tick(1); rst = 1'b1; tick(1);
`endif
    start = 1'b1; tick(1); start = 1'b0;
  endtask

  task automatic wait_show(input string tag, input int idx, input logic [31:0] exp_d);
    int n = 0;
    while (dbg_state == S_SHOW && n < 40) begin tick(1); n++; end
    while (dbg_state != S_SHOW && n < 80) begin tick(1); n++; end
    chk({tag, "_reach"}, 32'(dbg_state == S_SHOW), 32'd1);
    chk({tag, "_data"}, disp_data, exp_d);
    chk({tag, "_idx"}, 32'(disp_idx), 32'(idx));
  endtask

  // Counts cycles from the issue of operand exp_a to the first SHOW cycle.
  task automatic issue_gap(input string tag, input logic [31:0] exp_a, input int exp_gap,
                           input bit poke_start);
    int n = 0;
    while (!(add_valid && add_a == exp_a) && n < 80) begin tick(1); n++; end
    chk({tag, "_issue"}, 32'(add_valid), 32'd1);
    n = 0;
    while (dbg_state != S_SHOW && n < 40) begin
      tick(1); n++;
      if (n == 1) begin
        lat = 3;
        if (poke_start) start = 1'b1;
      end
      if (poke_start && n == 2) begin
        start = 1'b0;
        chk({tag, "_start_ign_state"}, 32'(dbg_state), 32'(S_WAIT));
        chk({tag, "_start_ign_addr"}, 32'(rom_addr), 32'd1);
      end
    end
    chk({tag, "_gap"}, 32'(n), 32'(exp_gap));
  endtask

  task automatic end_run(input string tag);
    tick(5);
`ifdef FPSEQ_LOOP_EN
    chk({tag, "_wrap_state"}, 32'(dbg_state), 32'(S_FETCH));
    chk({tag, "_wrap_addr"}, 32'(rom_addr), 32'd0);
    chk({tag, "_wrap_done"}, 32'(done), 32'd0);
    tick(3);
    chk({tag, "_wrap_busy"}, 32'(busy), 32'd1);
    chk({tag, "_wrap_done2"}, 32'(done), 32'd0);
`else
    chk({tag, "_done_pulse"}, 32'(done), 32'd1);
    chk({tag, "_done_busy"}, 32'(busy), 32'd0);
    chk({tag, "_done_state"}, 32'(dbg_state), 32'(S_DONE));
    tick(1);
    chk({tag, "_done_drop"}, 32'(done), 32'd0);
    chk({tag, "_hold_data"}, disp_data, tab_s[3]);
    chk({tag, "_hold_idx"}, 32'(disp_idx), 32'd3);
`endif
  endtask

  // ---------------- stimulus ----------------
  initial begin
    tick(3);
    chk("rst_addr", 32'(rom_addr), 32'd0);
    chk("rst_valid", 32'(add_valid), 32'd0);
    chk("rst_add_a", add_a, 32'd0);
    chk("rst_add_b", add_b, 32'd0);
    chk("rst_disp", disp_data, 32'd0);
    chk("rst_idx", 32'(disp_idx), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    rst = 1'b1;
    tick(2);

    // First pair: exact issue latency, result latency and dwell length
    start = 1'b1; tick(1); start = 1'b0;
    chk("a_fetch_state", 32'(dbg_state), 32'(S_FETCH));
    chk("a_fetch_busy", 32'(busy), 32'd1);
    chk("a_fetch_addr", 32'(rom_addr), 32'd0);
    tick(2);
    chk("a_issue_valid", 32'(add_valid), 32'd1);
    chk("a_issue_a", add_a, 32'h3F800000);
    chk("a_issue_b", add_b, 32'h40000000);
    tick(1);
    chk("a_issue_once", 32'(add_valid), 32'd0);
    chk("a_hold_a", add_a, 32'h3F800000);
    tick(2);
    chk("a_wait_state", 32'(dbg_state), 32'(S_WAIT));
    chk("a_not_yet", disp_data, 32'd0);
    tick(1);
    for (int i = 0; i < DWELL; i++) begin
      chk("a_dwell_data", disp_data, 32'h40400000);
      chk("a_dwell_state", 32'(dbg_state), 32'(S_SHOW));
      tick(1);
    end
    chk("a_next_fetch", 32'(dbg_state), 32'(S_FETCH));
    chk("a_next_addr", 32'(rom_addr), 32'd1);
    tick(2);
    chk("a_spacing_valid", 32'(add_valid), 32'd1);
    chk("a_spacing_a", add_a, 32'h40400000);

    for (int i = 1; i < NUM; i++) exp_q.push_back(tab_s[i]);
    for (int i = 1; i < NUM; i++) wait_show("run", i, exp_q.pop_front());
    chk("run_err", 32'(err), 32'd0);
    end_run("run");

    // Silent adder at idx 2
    mute_en = 1'b1; mute_a = 32'h40A00000;
    pulse_start();
    wait_show("tmo0", 0, tab_s[0]);
    wait_show("tmo1", 1, tab_s[1]);
    issue_gap("tmo", 32'h40A00000, TIMEOUT + 1, 1'b0);
    chk("tmo_qnan", disp_data, 32'h7FC00000);
    chk("tmo_err", 32'(err), 32'd1);
    wait_show("tmo3", 3, tab_s[3]);
    chk("tmo_err_sticky", 32'(err), 32'd1);
    end_run("tmo");
    mute_en = 1'b0;

    // Reset in the middle of SHOW of idx 1
    pulse_start();
    chk("restart_err_clr", 32'(err), 32'd0);
    wait_show("rs0", 0, tab_s[0]);
    wait_show("rs1", 1, tab_s[1]);
    tick(2);
    rst = 1'b0;
    #1;
    chk("rs_state", 32'(dbg_state), 32'(S_IDLE));
    chk("rs_busy", 32'(busy), 32'd0);
    chk("rs_addr", 32'(rom_addr), 32'd0);
    chk("rs_disp", disp_data, 32'd0);
    chk("rs_idx", 32'(disp_idx), 32'd0);
    chk("rs_add_a", add_a, 32'd0);
    chk("rs_valid", 32'(add_valid), 32'd0);
    chk("rs_done", 32'(done), 32'd0);
    tick(1);
    rst = 1'b1;
    inj_req++;
    tick(4);
    chk("rs_stray_disp", disp_data, 32'd0);
    chk("rs_stray_state", 32'(dbg_state), 32'(S_IDLE));
    start = 1'b1; tick(1); start = 1'b0;
    chk("rs_new_addr", 32'(rom_addr), 32'd0);
    chk("rs_new_state", 32'(dbg_state), 32'(S_FETCH));
    wait_show("rs_new0", 0, tab_s[0]);

    // Result on the timeout-expiry cycle, start pulsed during WAIT
    lat = TIMEOUT;
    issue_gap("coin", 32'h40400000, TIMEOUT + 1, 1'b1);
    chk("coin_data", disp_data, tab_s[1]);
    chk("coin_idx", 32'(disp_idx), 32'd1);
    chk("coin_err", 32'(err), 32'd0);
    wait_show("coin2", 2, tab_s[2]);
    wait_show("coin3", 3, tab_s[3]);
    end_run("coin");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
